bmult18_share_sched: RTL and testbench
======================================

# bmult18_share_sched

Round-robin scheduler that shares one pipelined 18x18 unsigned multiplier among `NREQ` requesters. The multiplier is the partial-product generator feeding the one-stage bitheap compressor. The scheduler does four things:
- arbitrates operand requests;
- issues at most one multiply per cycle;
- tracks each in-flight requester ID through the fixed compressor latency;
- buffers products in a result FIFO so a stalled consumer never drops a product.

It sits between the requesting engines and the multiplier datapath.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `LATENCY`, 1: multiplier pipeline depth in cycles, from operand capture to `mul_prod` valid; 1..4.
- `FIFO_DEPTH`, 4: result FIFO entries, power of two, ≥ `LATENCY`+1.
- `IDW`, `$clog2(NREQ)`: requester ID width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NREQ`  per-requester operand valid.
- `req_a`  in  `NREQ*18`  packed multiplicand; requester i at [18i+17:18i].
- `req_b`  in  `NREQ*18`  packed multiplier, same packing.
- `req_ready`  out  `NREQ`  one-hot grant; a handshake completes when valid & ready at a rising edge.
- `mul_issue`  out  1  operands on `mul_a`/`mul_b` are valid this cycle.
- `mul_a`, `mul_b`  out  18  registered operands to the datapath.
- `mul_prod`  in  36  datapath product, bits [35:0] of the compressor output.
- `resp_valid`  out  1  FIFO head valid.
- `resp_id`  out  `IDW`  requester ID of the head product.
- `resp_prod`  out  36  head product.
- `resp_ready`  in  1  consumer accepts the head.

## Operation
- **Credit.** `total` = in-flight count + FIFO count, both registered values. Arbitration is enabled only when `total < FIFO_DEPTH`. A FIFO pop in the same cycle does not free a credit until the next cycle.
- **Arbitration.**
  - Round-robin with pointer `last` (last granted index). Search order is `last+1`, `last+2`, … modulo `NREQ`.
  - `req_ready` is combinational from `req_valid`, `last` and the credit.
  - At most one bit of `req_ready` is high. It is never high without the corresponding `req_valid`.
  - `last` updates only on a completed handshake. On reset `last = NREQ-1`, so requester 0 has first priority.
- **Issue.** On a handshake, the next cycle drives `mul_issue=1`, `mul_a`/`mul_b` = the granted operands, and pushes the granted ID plus valid bit into a `LATENCY+1`-deep tag shift register. With no handshake, `mul_issue=0` and the operands hold their previous values.
- **Capture.** When the tag register's output stage is valid, `mul_prod` and the tag ID are written to the FIFO.
  - Overflow is impossible by the credit rule.
  - The write is unconditional; a simultaneous push and pop is legal.
- **Response.** The FIFO head drives `resp_*`. The head is popped on `resp_valid & resp_ready`. Products leave in issue order.
- **Arithmetic.** Unsigned 18x18 produces 36 bits. No truncation; the compressor's bit 36 is not used.
- **Reset values.**
  - `req_ready=0`, `mul_issue=0`, `mul_a=0`, `mul_b=0`, `resp_valid=0`, `resp_id=0`, `resp_prod=0`.
  - FIFO empty, tag register cleared, `last=NREQ-1`.
- **Reset mid-operation.** All in-flight and buffered products are discarded. The scheduler emits no response for them. It accepts new requests from the first cycle after `rst` deasserts.

## Timing
- Handshake at edge E0, then:
  - `mul_issue` is high in cycle E0..E1;
  - `mul_prod` is valid LATENCY cycles later and written at edge E(1+LATENCY);
  - `resp_valid` rises after that edge when the FIFO was empty.
- Minimum request-to-response latency is `LATENCY+2` cycles. This is 3 for the default.
- Throughput is one issue per cycle while the credit allows and the consumer drains each cycle.
- With `resp_ready` held low, exactly `FIFO_DEPTH` requests are accepted, then all `req_ready` stay low.
- After the first pop, one cycle elapses before the next grant.
- `resp_*` are stable while `resp_valid & !resp_ready`.

## Configuration
- `BMULT_SCHED_STATS_EN` defined:
  - adds output `stat_issue_cnt` (32 bits), incremented on every handshake;
  - adds output `stat_stall_cnt` (32 bits), incremented on every cycle where some `req_valid` is high but the credit blocks arbitration;
  - both counters reset to 0 on `rst` and wrap at 2^32.
- Undefined: the stat ports and counter logic are absent. All other behaviour is identical.

## Test plan
- **Single request.** Requester 2, a=0x3FFFF, b=0x3FFFF, `resp_ready=1` → `resp_valid` 3 cycles after the handshake, `resp_id=2`, `resp_prod=0xFFFF80001`.
- **Contention.** All 4 requesters hold `req_valid` continuously, `resp_ready=1` → grants 0,1,2,3,0,… one per cycle; responses in the same ID order with correct products.
- **Backpressure.** `resp_ready=0`, all requesters valid → exactly 4 handshakes, then `req_ready=0`. Set `resp_ready=1` → 4 responses drain in order, and the next grant follows one cycle after the first pop.
- **Reset mid-flight.** Assert `rst` with 2 products in flight and 1 buffered → all outputs at reset values the next cycle; no stale response ever appears; a new request afterwards completes normally.
- **Zero and identity.** a=0, b=0x2ABCD → product 0. a=1, b=0x2ABCD → product 0x2ABCD.
- **Stats (macro defined).** The backpressure scenario above with 10 blocked cycles → `stat_issue_cnt=4`, `stat_stall_cnt=10`.

Source files
------------

// File: rtl/bmult18_share_sched.sv
// Round-robin scheduler sharing one pipelined 18x18 multiplier; products and their IDs are returned through an in-order result FIFO.
// Latency: handshake to resp_valid is LATENCY+2 cycles minimum.
// Backpressure: credits (in-flight + buffered) cap grants at FIFO_DEPTH. Optional stat counters are enabled by BMULT_SCHED_STATS_EN.

module bmult18_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    output logic                    head_vld,
    output logic [W-1:0]            head_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage is cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign head_vld  = (count != '0);
    assign head_data = mem[rptr];
endmodule

module bmult18_share_sched #(
    parameter int NREQ       = 4,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*18-1:0]   req_a,
    input  logic [NREQ*18-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 mul_issue,
    output logic [17:0]          mul_a,
    output logic [17:0]          mul_b,
    input  logic [35:0]          mul_prod,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [35:0]          resp_prod,
    input  logic                 resp_ready
`ifdef BMULT_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_issue_cnt,
    output logic [31:0]          stat_stall_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 2);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    logic [IDW-1:0]  last;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    logic            found;
    int              idx;
    logic            hs;
    logic [17:0]     sel_a;
    logic [17:0]     sel_b;

    logic [LATENCY:0] tag_vld;
    logic [IDW-1:0]   tag_id [LATENCY+1];

    logic [FW-1:0]   fcount;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   total;
    logic            cred_avail;
    logic            credit_ok;
    logic [IDW+35:0] head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LATENCY; i++) begin
            inflight = inflight + CW'(tag_vld[i]);
        end
        total      = inflight + CW'(fcount);
        cred_avail = (total < CW'(FIFO_DEPTH));
        credit_ok  = cred_avail && !rst;
    end

    // Search starts one past the last winner so every requester is served in turn.
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (credit_ok && !found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gid        = IDW'(idx);
                found      = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign hs        = found;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[18*i +: 18];
                sel_b = req_b[18*i +: 18];
            end
        end
    end

    // Tag pipe mirrors the datapath so the ID arrives at its output stage together with mul_prod.
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= IDW'(NREQ - 1);
            mul_issue <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            tag_vld   <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            mul_issue <= hs;
            if (hs) begin
                mul_a <= sel_a;
                mul_b <= sel_b;
                last  <= gid;
            end
            tag_vld   <= {tag_vld[LATENCY-1:0], hs};
            tag_id[0] <= gid;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    bmult18_fifo #(
        .W     (IDW + 36),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_vld[LATENCY]),
        .push_data ({tag_id[LATENCY], mul_prod}),
        .pop       (resp_valid & resp_ready),
        .head_vld  (resp_valid),
        .head_data (head),
        .count     (fcount)
    );

    assign {resp_id, resp_prod} = head;

`ifdef BMULT_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issue_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (hs) begin
                stat_issue_cnt <= stat_issue_cnt + 32'd1;
            end
            if ((|req_valid) && !cred_avail) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_bmult18_share_sched.sv
// Directed bench for bmult18_share_sched with a one-stage multiplier model driving mul_prod.
module tb_bmult18_share_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [71:0] req_a;
    logic [71:0] req_b;
    logic [3:0]  req_ready;
    logic        mul_issue;
    logic [17:0] mul_a;
    logic [17:0] mul_b;
    logic [35:0] mul_prod;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [35:0] resp_prod;
    logic        resp_ready;
`ifdef BMULT_SCHED_STATS_EN
    logic [31:0] stat_issue_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [17:0] ta [4];
    logic [17:0] tb [4];
    logic [35:0] tp [4];

    always #5 clk = ~clk;

    always @(posedge clk) mul_prod <= {18'd0, mul_a} * {18'd0, mul_b};

    bmult18_share_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_issue  (mul_issue),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_prod   (mul_prod),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_prod  (resp_prod),
        .resp_ready (resp_ready)
`ifdef BMULT_SCHED_STATS_EN
        ,
        .stat_issue_cnt (stat_issue_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [17:0] a, input logic [17:0] b);
        req_a[18*i +: 18] = a;
        req_b[18*i +: 18] = b;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_req_ready"},  64'(req_ready),  64'd0);
        check({pfx, "_mul_issue"},  64'(mul_issue),  64'd0);
        check({pfx, "_mul_a"},      64'(mul_a),      64'd0);
        check({pfx, "_mul_b"},      64'(mul_b),      64'd0);
        check({pfx, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({pfx, "_resp_id"},    64'(resp_id),    64'd0);
        check({pfx, "_resp_prod"},  64'(resp_prod),  64'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < 4; i++) set_op(i, ta[i], tb[i]);
    endtask

    initial begin
        ta[0] = 18'h00003; tb[0] = 18'h00004; tp[0] = 36'h00000000C;
        ta[1] = 18'h00005; tb[1] = 18'h00006; tp[1] = 36'h00000001E;
        ta[2] = 18'h00007; tb[2] = 18'h3FFFF; tp[2] = 36'h0001BFFF9;
        ta[3] = 18'h20000; tb[3] = 18'h3FFFF; tp[3] = 36'h7FFFE0000;

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        #1;
        check_reset("rst");
`ifdef BMULT_SCHED_STATS_EN
        check("rst_stat_issue", 64'(stat_issue_cnt), 64'd0);
        check("rst_stat_stall", 64'(stat_stall_cnt), 64'd0);
`endif
        rst = 1'b0;

        // Single request, requester 2, full-scale operands
        set_op(2, 18'h3FFFF, 18'h3FFFF);
        req_valid  = 4'b0100;
        resp_ready = 1'b1;
        #1 check("single_grant", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        #1;
        check("single_issue", 64'(mul_issue), 64'd1);
        check("single_mul_a", 64'(mul_a), 64'h3FFFF);
        check("single_mul_b", 64'(mul_b), 64'h3FFFF);
        check("single_early_resp1", 64'(resp_valid), 64'd0);
        tick();
        #1;
        check("single_issue_drop", 64'(mul_issue), 64'd0);
        check("single_early_resp2", 64'(resp_valid), 64'd0);
        tick();
        #1;
        check("single_resp_valid", 64'(resp_valid), 64'd1);
        check("single_resp_id", 64'(resp_id), 64'd2);
        check("single_resp_prod", 64'(resp_prod), 64'hFFFF80001);
        tick();
        #1 check("single_resp_gone", 64'(resp_valid), 64'd0);

        // Contention: all requesters valid, consumer always ready
        do_reset();
        load_table();
        resp_ready = 1'b1;
        req_valid  = 4'hF;
        for (int c = 0; c <= 10; c++) begin
            if (c == 8) req_valid = '0;
            #1;
            if (c < 8) check("cont_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
            else       check("cont_grant_idle", 64'(req_ready), 64'd0);
            if (c >= 3) begin
                check("cont_resp_valid", 64'(resp_valid), 64'd1);
                check("cont_resp_id", 64'(resp_id), 64'((c - 3) % 4));
                check("cont_resp_prod", 64'(resp_prod), 64'(tp[(c - 3) % 4]));
            end
            tick();
        end
        #1 check("cont_drained", 64'(resp_valid), 64'd0);

        // Backpressure: consumer stalled, credits run out after FIFO_DEPTH grants
        do_reset();
        load_table();
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #1 check("bp_grant", 64'(req_ready), 64'(4'b0001 << c));
            tick();
        end
        for (int c = 4; c <= 12; c++) begin
            #1;
            check("bp_blocked", 64'(req_ready), 64'd0);
            check("bp_head_id", 64'(resp_id), 64'd0);
            tick();
        end
        #1;
        check("bp_blocked_last", 64'(req_ready), 64'd0);
        check("bp_head_valid", 64'(resp_valid), 64'd1);
        check("bp_head_prod", 64'(resp_prod), 64'(tp[0]));
        resp_ready = 1'b1;
        tick();
        #1;
        check("bp_regrant", 64'(req_ready), 64'h1);
        check("bp_resp1_id", 64'(resp_id), 64'd1);
        check("bp_resp1_prod", 64'(resp_prod), 64'(tp[1]));
`ifdef BMULT_SCHED_STATS_EN
        check("bp_stat_issue", 64'(stat_issue_cnt), 64'd4);
        check("bp_stat_stall", 64'(stat_stall_cnt), 64'd10);
`endif
        tick();
        req_valid = '0;
        #1;
        check("bp_idle", 64'(req_ready), 64'd0);
        check("bp_resp2_id", 64'(resp_id), 64'd2);
        tick();
        #1;
        check("bp_resp3_id", 64'(resp_id), 64'd3);
        check("bp_resp3_prod", 64'(resp_prod), 64'(tp[3]));
        tick();
        #1;
        check("bp_resp4_valid", 64'(resp_valid), 64'd1);
        check("bp_resp4_id", 64'(resp_id), 64'd0);
        check("bp_resp4_prod", 64'(resp_prod), 64'(tp[0]));
        tick();
        #1 check("bp_drained", 64'(resp_valid), 64'd0);

        // Reset with two products in flight and one buffered
        do_reset();
        load_table();
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        tick();
        tick();
        tick();
        #1;
        check("mid_buffered", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        #1 check("mid_rst_gate", 64'(req_ready), 64'd0);
        tick();
        #1;
        check_reset("mid");
        rst        = 1'b0;
        resp_ready = 1'b1;
        set_op(1, 18'h00000, 18'h2ABCD);
        req_valid  = 4'b0010;
        #1 check("mid_new_grant", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        #1 check("mid_no_stale1", 64'(resp_valid), 64'd0);
        tick();
        #1 check("mid_no_stale2", 64'(resp_valid), 64'd0);
        tick();
        #1;
        check("zero_resp_valid", 64'(resp_valid), 64'd1);
        check("zero_resp_id", 64'(resp_id), 64'd1);
        check("zero_resp_prod", 64'(resp_prod), 64'd0);
        tick();
        #1 check("mid_no_stale3", 64'(resp_valid), 64'd0);

        // Identity multiplicand on requester 3
        set_op(3, 18'h00001, 18'h2ABCD);
        req_valid = 4'b1000;
        #1 check("ident_grant", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        check("ident_resp_valid", 64'(resp_valid), 64'd1);
        check("ident_resp_id", 64'(resp_id), 64'd3);
        check("ident_resp_prod", 64'(resp_prod), 64'h2ABCD);
        tick();
        #1 check("ident_drained", 64'(resp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
